// File: rtl/uart_rx_fifo_test.sv
// uart_rx_fifo_test: 16x-oversampled UART receiver into a 2**FIFO_AW byte FIFO popped by a button; CLK/RESET, UART_RXD/BTN_RD in; LED, done, full, empty, frame_err, overrun out
module uart_rx_fifo_test #(
  parameter int DVSR = 54,
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            UART_RXD,
  input  logic            BTN_RD,
  output logic [DBIT-1:0] LED,
  output logic            done,
  output logic            full,
  output logic            empty,
  output logic            frame_err,
  output logic            overrun
);
  localparam int CW = $clog2(DVSR + 1);
  localparam int NW = $clog2(DBIT + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [3:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic [CW-1:0] cnt;
  logic rx_m, rx_s, btn_m, btn_s, btn_q;
  logic tick, push, ferr, pop, do_pop, do_push;
  logic [FIFO_AW:0] wp, rp;
  logic [DBIT-1:0] mem [2**FIFO_AW];
  assign tick = cnt == CW'(DVSR - 1);
  assign empty = wp == rp;
  assign full = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign pop = btn_s && !btn_q;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    b_n = b;
    push = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        s_n = '0;
      end
      START: if (tick) begin
        if (s == 4'd7) begin
          state_n = rx_s ? IDLE : DATA;
          s_n = '0;
          n_n = '0;
        end else s_n = s + 4'd1;
      end
      DATA: if (tick) begin
        if (s == 4'd15) begin
          s_n = '0;
          b_n = {rx_s, b[DBIT-1:1]};
          if (n == NW'(DBIT - 1)) state_n = STOP;
          else n_n = n + 1'b1;
        end else s_n = s + 4'd1;
      end
      STOP: if (tick) begin
        if (s == 4'(SB_TICK - 1)) begin
          state_n = IDLE;
          push = rx_s;
          ferr = !rx_s;
        end else s_n = s + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      {rx_m, rx_s} <= 2'b11;
      {btn_m, btn_s, btn_q} <= '0;
      cnt <= '0;
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      wp <= '0;
      rp <= '0;
      LED <= '0;
      done <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      {rx_m, rx_s} <= {UART_RXD, rx_m};
      {btn_m, btn_s, btn_q} <= {BTN_RD, btn_m, btn_s};
      cnt <= tick ? '0 : cnt + 1'b1;
      state <= state_n;
      s <= s_n;
      n <= n_n;
      b <= b_n;
      done <= push;
      frame_err <= frame_err | ferr;
      overrun <= overrun | (push && !do_push);
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) begin
        rp <= rp + 1'b1;
        LED <= mem[rp[FIFO_AW-1:0]];
      end
    end
  always_ff @(posedge CLK)
    if (do_push) mem[wp[FIFO_AW-1:0]] <= b;
endmodule

// File: tb/tb_uart_rx_fifo_test.sv
// tb_uart_rx_fifo_test: directed self-checking bench for uart_rx_fifo_test with DVSR=4 (64 CLK per bit)
module tb_uart_rx_fifo_test;
  logic CLK = 0, RESET = 1, UART_RXD = 1, BTN_RD = 0;
  logic [7:0] LED;
  logic done, full, empty, frame_err, overrun;
  int checks = 0, errors = 0, cyc = 0, e0 = 0, done_cnt = 0, done_at = 0, s0 = 0, d0 = 0;
  uart_rx_fifo_test #(.DVSR(4)) dut (
    .CLK(CLK), .RESET(RESET), .UART_RXD(UART_RXD), .BTN_RD(BTN_RD), .LED(LED),
    .done(done), .full(full), .empty(empty), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) if (done) begin
    done_cnt++;
    done_at = cyc;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_cyc(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask
  task automatic do_reset;
    RESET = 1;
    wait_cyc(3);
    e0 = cyc;
    RESET = 0;
  endtask
  task automatic drive(input logic v, input int len);
    UART_RXD = v;
    wait_cyc(len);
  endtask
  task automatic send(input logic [7:0] d, input logic ok);
    drive(1'b0, 64);
    for (int i = 0; i < 8; i++) drive(d[i], 64);
    if (ok) drive(1'b1, 64);
    else begin
      drive(1'b0, 48);
      drive(1'b1, 16);
    end
    drive(1'b1, 32);
  endtask
  task automatic read_btn;
    BTN_RD = 1;
    wait_cyc(4);
    BTN_RD = 0;
    wait_cyc(4);
  endtask
  initial begin
    do_reset;
    check("rst_led", LED, 0);
    check("rst_done", done, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    s0 = cyc;
    d0 = done_cnt;
    send(8'hA5, 1);
    check("a5_done", done_cnt, d0 + 1);
    check("a5_time", (done_at - s0 >= 600) && (done_at - s0 <= 620), 1);
    check("a5_empty0", empty, 0);
    read_btn;
    check("a5_led", LED, 8'hA5);
    check("a5_empty1", empty, 1);
    d0 = done_cnt;
    send(8'h3C, 0);
    check("fe_flag", frame_err, 1);
    check("fe_done", done_cnt, d0);
    check("fe_empty", empty, 1);
    read_btn;
    check("fe_led_hold", LED, 8'hA5);
    send(8'h11, 1);
    check("pre_rst_empty", empty, 0);
    d0 = done_cnt;
    fork
      send(8'hFF, 1);
      begin
        wait_cyc(288);
        do_reset;
      end
    join
    check("mid_led", LED, 0);
    check("mid_empty", empty, 1);
    check("mid_full", full, 0);
    check("mid_ferr", frame_err, 0);
    check("mid_ovr", overrun, 0);
    check("mid_done", done_cnt, d0);
    send(8'h81, 1);
    read_btn;
    check("mid_81", LED, 8'h81);
    check("mid_empty2", empty, 1);
    do_reset;
    d0 = done_cnt;
    drive(1'b0, 16);
    drive(1'b1, 640);
    check("gl_done", done_cnt, d0);
    check("gl_ferr", frame_err, 0);
    check("gl_empty", empty, 1);
    send(8'h5A, 1);
    check("gl_done2", done_cnt, d0 + 1);
    read_btn;
    check("gl_5a", LED, 8'h5A);
    do_reset;
    d0 = done_cnt;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1);
      if (i == 3) check("ov_full3", full, 0);
      if (i == 4) begin
        check("ov_full4", full, 1);
        check("ov_ovr4", overrun, 0);
      end
    end
    check("ov_ovr5", overrun, 1);
    check("ov_done", done_cnt, d0 + 5);
    for (int i = 1; i <= 4; i++) begin
      read_btn;
      check("ov_led", LED, i);
    end
    check("ov_empty", empty, 1);
    read_btn;
    check("ov_led_hold", LED, 8'h04);
    do_reset;
    for (int i = 1; i <= 4; i++) send(8'(i * 16), 1);
    check("sim_full0", full, 1);
    while ((cyc - e0) % 4 != 0) wait_cyc(1);
    fork
      send(8'h77, 1);
      begin
        wait_cyc(605);
        BTN_RD = 1;
        wait_cyc(4);
        BTN_RD = 0;
      end
    join
    check("sim_ovr", overrun, 0);
    check("sim_full", full, 1);
    check("sim_led10", LED, 8'h10);
    for (int i = 2; i <= 4; i++) begin
      read_btn;
      check("sim_led", LED, i * 16);
    end
    read_btn;
    check("sim_77", LED, 8'h77);
    check("sim_empty", empty, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
